clock_set_controller: RTL

- Sequencing controller for the three BCD time-of-day counters (hours 00-23, minutes 00-59, seconds 00-59) of the digital clock.
- In RUN it advances seconds on each 1 Hz tick and ripples the counters' registered carries upward.
- In the SET modes it converts button edges into single-cycle add/sub strobes for the field being edited, freezes time, and suppresses carries.
- It sits between the debounced button synchronizers and the counter instances.

---
 rtl/clock_set_controller_if.sv | 37 +++
 rtl/clock_set_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller_if.sv
// Signal bundle between the clock set controller, the button synchronizers
// and the three BCD time-of-day counters.
// master: the surrounding logic (synchronizers in, counters out).
// slave : the controller itself.
interface clock_set_controller_if;
   logic       tick;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic       sec_cout;
   logic       min_cout;

   logic       sec_add;
   logic       sec_sub;
   logic       sec_clr;
   logic       min_add;
   logic       min_sub;
   logic       hour_add;
   logic       hour_sub;
   logic       time_hold;
   logic [1:0] mode;
   logic       blank_hour;
   logic       blank_min;
   logic       blank_sec;

   modport master (
      output tick, btn_mode, btn_up, btn_down, sec_cout, min_cout,
      input  sec_add, sec_sub, sec_clr, min_add, min_sub, hour_add, hour_sub,
      input  time_hold, mode, blank_hour, blank_min, blank_sec
   );

   modport slave (
      input  tick, btn_mode, btn_up, btn_down, sec_cout, min_cout,
      output sec_add, sec_sub, sec_clr, min_add, min_sub, hour_add, hour_sub,
      output time_hold, mode, blank_hour, blank_min, blank_sec
   );
endinterface

// File: rtl/clock_set_controller.sv
// Sequencing controller for the hours/minutes/seconds BCD counters.
// RUN: 1 Hz tick advances seconds, counter carries ripple upward.
// SET_HOUR / SET_MIN / SET_SEC: button edges become single-cycle edit
// strobes, time is frozen, carries are ignored, and an idle timeout
// returns to RUN.
// Optional build macro CLOCK_SET_BLINK_EN adds a blink counter that blanks
// the field being edited every BLINK_CYCLES clk cycles; without it the
// blank outputs are tied low.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RUN      | normal timekeeping, ticks and carries act
// ST_SET_HOUR | editing hours, up/down -> hour_add/hour_sub
// ST_SET_MIN  | editing minutes, up/down -> min_add/min_sub
// ST_SET_SEC  | editing seconds, up or down -> sec_clr
module clock_set_controller #(
   parameter int unsigned TIMEOUT_TICKS = 30,
   parameter int unsigned BLINK_CYCLES  = 25000000
) (
   input  logic                  clk,
   input  logic                  rst,
   clock_set_controller_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10,
      ST_SET_SEC  = 2'b11
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);

   // Out-of-range parameters are caught at elaboration.
   if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255 || BLINK_CYCLES < 2) begin : g_param_check
      $error("clock_set_controller: TIMEOUT_TICKS must be 1..255 and BLINK_CYCLES >= 2");
   end

   state_t     state;
   state_t     nxt_state;
   logic       mode_q;
   logic       up_q;
   logic       down_q;
   logic       primed;
   logic [7:0] tcnt;
   logic [7:0] tcnt_nxt;

   logic       mode_e;
   logic       up_e;
   logic       down_e;
   logic       in_set;
   logic       accept;
   logic       timeout;

   // Edge decode, edit acceptance and next-state selection.
   // primed masks the first cycle after reset so a button held through
   // reset is not mistaken for a fresh press.
   always_comb begin
      mode_e    = primed & bus.btn_mode & ~mode_q;
      up_e      = primed & bus.btn_up   & ~up_q;
      down_e    = primed & bus.btn_down & ~down_q;
      in_set    = (state != ST_RUN);
      accept    = 1'b0;
      timeout   = 1'b0;
      nxt_state = state;
      tcnt_nxt  = tcnt;

      if (in_set && !mode_e) begin
         if (state == ST_SET_SEC) accept = up_e | down_e;
         else                     accept = up_e ^ down_e;
      end

      timeout = in_set & bus.tick & ~accept & (tcnt == TIMEOUT_LAST);

      if (mode_e) begin
         unique case (state)
            ST_RUN:      nxt_state = ST_SET_HOUR;
            ST_SET_HOUR: nxt_state = ST_SET_MIN;
            ST_SET_MIN:  nxt_state = ST_SET_SEC;
            ST_SET_SEC:  nxt_state = ST_RUN;
            default:     nxt_state = ST_RUN;
         endcase
         tcnt_nxt = 8'd0;
      end else if (accept) begin
         tcnt_nxt = 8'd0;
      end else if (timeout) begin
         nxt_state = ST_RUN;
         tcnt_nxt  = 8'd0;
      end else if (in_set && bus.tick) begin
         tcnt_nxt = tcnt + 8'd1;
      end
   end

   // Input sampling for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= 1'b0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
         primed <= 1'b0;
      end else begin
         mode_q <= bus.btn_mode;
         up_q   <= bus.btn_up;
         down_q <= bus.btn_down;
         primed <= 1'b1;
      end
   end

   // FSM: state, timeout counter and registered strobes / status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         tcnt          <= 8'd0;
         bus.mode      <= 2'b00;
         bus.time_hold <= 1'b0;
         bus.sec_add   <= 1'b0;
         bus.sec_sub   <= 1'b0;
         bus.sec_clr   <= 1'b0;
         bus.min_add   <= 1'b0;
         bus.min_sub   <= 1'b0;
         bus.hour_add  <= 1'b0;
         bus.hour_sub  <= 1'b0;
      end else begin
         state         <= nxt_state;
         tcnt          <= tcnt_nxt;
         bus.mode      <= nxt_state;
         bus.time_hold <= (nxt_state != ST_RUN);

         // Seconds are only ever zeroed while editing, never decremented.
         bus.sec_sub  <= 1'b0;
         bus.sec_add  <= (state == ST_RUN) & bus.tick;
         bus.min_add  <= ((state == ST_RUN) & bus.sec_cout) |
                         ((state == ST_SET_MIN) & accept & up_e);
         bus.hour_add <= ((state == ST_RUN) & bus.min_cout) |
                         ((state == ST_SET_HOUR) & accept & up_e);
         bus.min_sub  <= (state == ST_SET_MIN)  & accept & down_e;
         bus.hour_sub <= (state == ST_SET_HOUR) & accept & down_e;
         bus.sec_clr  <= (state == ST_SET_SEC)  & accept;
      end
   end

`ifdef CLOCK_SET_BLINK_EN
   localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic               blink_clr;

   // Restart the blink so the edited field is visible right after a change.
   assign blink_clr = (mode_e && (nxt_state != ST_RUN)) || accept;

   // Free-running blink half-period counter and phase toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_clr) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   assign bus.blank_hour = (state == ST_SET_HOUR) & blink_phase;
   assign bus.blank_min  = (state == ST_SET_MIN)  & blink_phase;
   assign bus.blank_sec  = (state == ST_SET_SEC)  & blink_phase;
`else
   assign bus.blank_hour = 1'b0;
   assign bus.blank_min  = 1'b0;
   assign bus.blank_sec  = 1'b0;
`endif

endmodule
